shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter: WIDTH, 32, data width; fixed at 32, since the shift amount is 5 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream offers an operation.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
REQ-007 a  input  32  operand.
REQ-008 shamt  input  5  shift amount, 0..31.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 y  output  32  result.
REQ-012 op_count  output  16  number of results consumed since reset.

Function
REQ-013 The block SHALL be a two-stage pipeline: S1 registers op/a/shamt; S2 registers the computed y.
REQ-014 Transfers SHALL occur only on valid&&ready: in_valid&&in_ready at the input, out_valid&&out_ready at the output.
REQ-015 S2 SHALL accept when !s2_valid || out_ready; S1 SHALL advance into S2 when s1_valid && S2 accepts.
REQ-016 in_ready SHALL equal !s1_valid || (S1 advancing this cycle), combinationally, so back-to-back ops sustain 1 result/cycle.
REQ-017 Latency SHALL be exactly 2 cycles: out_valid is high on the second rising edge after the input transfer, absent stall.
REQ-018 While out_valid && !out_ready, y and out_valid SHALL hold stable; no transaction SHALL be dropped, duplicated, or reordered.
REQ-019 SLL: y[i] = a[i-shamt] for i >= shamt, else 0.
REQ-020 SRL: y[i] = a[i+shamt] for i+shamt <= 31, else 0.
REQ-021 SRA: as SRL, but vacated bits are filled with a[31].
REQ-022 shamt = 0 SHALL return a unchanged for every op.
REQ-023 The shift SHALL be computed between S1 and S2 (one combinational stage); nothing is computed before S1.
REQ-024 op_count SHALL increment by 1 on each output transfer; it wraps from 0xFFFF to 0x0000.
REQ-025 If an input and an output transfer occur in the same cycle, both SHALL complete, and pipeline occupancy SHALL be updated accordingly.

Reset
REQ-026 On rst, s1_valid, s2_valid, y, and op_count SHALL clear to 0 immediately (asynchronous clear).
REQ-027 Reset mid-operation SHALL discard all in-flight ops; out_valid reads 0 while rst is high and on the first cycle after release.
REQ-028 in_ready SHALL be 1 after reset release (pipeline empty).

Configuration
REQ-029 Macro SHIFT_ROTATE_EN: when defined, op 11 SHALL perform rotate-right, y[i] = a[(i+shamt) mod 32].
REQ-030 Without SHIFT_ROTATE_EN, op 11 SHALL produce y = 0 with normal handshake and latency.

Structure
REQ-031 Package shift_pkg SHALL hold: typedef enum shift_op_t (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR), and constants WIDTH = 32 and SHAMT_W = 5.
REQ-032 Each result bit SHALL be produced by one instance of the existing mux32 sub-module (32 instances), with s = shamt (or 31-shamt-adjusted index for SLL).
REQ-033 Each mux32 instance's 32-bit input vector SHALL be pre-arranged per op, including the fill bits.

Verification
REQ-034 SLL a=0x00000001, shamt=31 -> y=0x80000000, out_valid 2 cycles after accept.
REQ-035 SRA a=0x80000000, shamt=4 -> y=0xF8000000; SRL with the same operands -> y=0x08000000.
REQ-036 Backpressure: issue 3 back-to-back ops with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, third op held by upstream, then all 3 results emerge in order, op_count=3.
REQ-037 ROR a=0x00000001, shamt=1 -> y=0x80000000 with SHIFT_ROTATE_EN defined; y=0x00000000 without it.
REQ-038 Assert rst while S1 and S2 are both valid -> out_valid=0 and y=0 immediately; in_ready=1 after release; op_count=0.
REQ-039 Random 1024 ops with random out_ready, checked against a behavioural model using the === comparison -> 0 mismatches, op_count=1024.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_pipe block.
package shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    // Mirrors bit order so a left shift can reuse the right-shift mux arrangement.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_pipe_mux32.sv
// 32:1 single-bit multiplexer; one instance produces one result bit of shift_pipe.
module mux32
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0]   d_i,
    input  logic [SHAMT_W-1:0] s_i,
    output logic               y_o
);

    assign y_o = d_i[s_i];

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready barrel shifter (SLL/SRL/SRA, plus ROR when SHIFT_ROTATE_EN is defined).
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic [15:0]        op_count
);

    logic               s1_valid_q, s1_valid_d;
    shift_op_t          s1_op_q;
    logic [WIDTH-1:0]   s1_a_q;
    logic [SHAMT_W-1:0] s1_shamt_q;
    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [15:0]        op_count_q, op_count_d;

    logic               s2_accept_s;
    logic               s1_adv_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic [WIDTH-1:0]   a_rev_s;
    logic [WIDTH-1:0]   mux_in_s [WIDTH];
    logic [WIDTH-1:0]   shift_res_s;

    assign s2_accept_s = !s2_valid_q || out_ready;
    assign s1_adv_s    = s1_valid_q && s2_accept_s;
    assign in_ready    = !s1_valid_q || s1_adv_s;
    assign in_fire_s   = in_valid && in_ready;
    assign out_fire_s  = s2_valid_q && out_ready;
    assign a_rev_s     = bit_reverse(s1_a_q);

    // Per result bit i, entry k of the mux vector is the bit selected when shamt == k, fill included.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mux_in_s[i] = {WIDTH{1'b0}};
            case (s1_op_q)
                SHIFT_SLL: mux_in_s[i] = a_rev_s >> (WIDTH - 1 - i);
                SHIFT_SRL: mux_in_s[i] = s1_a_q >> i;
                SHIFT_SRA: mux_in_s[i] = WIDTH'($signed(s1_a_q) >>> i);
`ifdef SHIFT_ROTATE_EN
                SHIFT_ROR: mux_in_s[i] = (s1_a_q >> i) | (s1_a_q << (WIDTH - i));
`else
                SHIFT_ROR: mux_in_s[i] = {WIDTH{1'b0}};
`endif
                default:   mux_in_s[i] = {WIDTH{1'b0}};
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        mux32 u_mux (
            .d_i (mux_in_s[g]),
            .s_i (s1_shamt_q),
            .y_o (shift_res_s[g])
        );
    end

    // Next-state for occupancy, result register and consumed-result counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        op_count_d = op_count_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            y_d        = shift_res_s;
        end else if (out_fire_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (out_fire_s) begin
            op_count_d = op_count_q + 16'd1;
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Pipeline state; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= SHIFT_SLL;
            s1_a_q     <= {WIDTH{1'b0}};
            s1_shamt_q <= {SHAMT_W{1'b0}};
            s2_valid_q <= 1'b0;
            y_q        <= {WIDTH{1'b0}};
            op_count_q <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            op_count_q <= op_count_d;
            if (in_fire_s) begin
                s1_op_q    <= shift_op_t'(op);
                s1_a_q     <= a;
                s1_shamt_q <= shamt;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases, backpressure, reset mid-flight, random traffic.
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    shift_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        logic [31:0] r;
        r = 32'h0;
        case (o)
            2'b00: for (int i = 0; i < 32; i++) r[i] = (i >= int'(s)) ? v[i - int'(s)] : 1'b0;
            2'b01: for (int i = 0; i < 32; i++) r[i] = (i + int'(s) <= 31) ? v[i + int'(s)] : 1'b0;
            2'b10: for (int i = 0; i < 32; i++) r[i] = (i + int'(s) <= 31) ? v[i + int'(s)] : v[31];
`ifdef SHIFT_ROTATE_EN
            2'b11: for (int i = 0; i < 32; i++) r[i] = v[(i + int'(s)) % 32];
`else
            2'b11: r = 32'h0;
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = 32'h0; shamt = 5'd0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got %h want 0000", op_count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    endtask

    // One op with latency check: out_valid must rise exactly on the second edge after accept.
    task automatic test_directed(input string name, input logic [1:0] o, input logic [31:0] v,
                                 input logic [4:0] s, input logic [31:0] exp_y);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = v; shamt = s; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0; a = 32'h0; shamt = 5'd0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b want 0", name, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got out_valid %b want 1", name, out_valid); end
        checks++; if (y !== exp_y) begin errors++; $display("FAIL %s_y got %h want %h", name, y, exp_y); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic [31:0] ops_a[3];
        int issued = 0;
        int got = 0;
        int cyc = 0;
        do_reset();
        ops_a[0] = 32'h1234_5678; ops_a[1] = 32'h8000_0001; ops_a[2] = 32'hF0F0_0F0F;
        while ((got < 3) && (cyc < 50)) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (issued < 3);
            op = 2'b01; shamt = 5'd3; a = (issued < 3) ? ops_a[issued] : 32'h0;
            #1;
            if (cyc == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop got %b want 0 (issued %0d)", in_ready, issued); end
                checks++; if (issued != 2) begin errors++; $display("FAIL bp_accepted_before_stall got %0d want 2", issued); end
            end
            if (out_valid && out_ready) begin
                checks++; if (y !== exp_q[0]) begin errors++; $display("FAIL bp_order got %h want %h", y, exp_q[0]); end
                void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(op, a, shamt));
                issued++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (got != 3) begin errors++; $display("FAIL bp_results got %0d want 3", got); end
        checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL bp_op_count got %0d want 3", op_count); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; shamt = 5'd1;
        @(negedge clk);
        a = 32'hCAFE_F00D;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_s2_full got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_s1_full got in_ready %b want 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL mid_rst_y got %h want 00000000", y); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL mid_rst_op_count got %0d want 0", op_count); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_out_valid got %b want 0", out_valid); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL mid_release_op_count got %0d want 0", op_count); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic        hold = 1'b0;
        logic [31:0] hold_y = 32'h0;
        int issued = 0;
        int got = 0;
        int cyc = 0;
        do_reset();
        while ((got < 1024) && (cyc < 20000)) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if ((out_valid !== 1'b1) || (y !== hold_y)) begin
                    errors++; $display("FAIL rnd_stall_hold got valid %b y %h want 1 %h", out_valid, y, hold_y);
                end
            end
            in_valid  = (issued < 1024) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = $urandom;
            shamt     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious got %h want no result", y);
                end else begin
                    if (y !== exp_q[0]) begin errors++; $display("FAIL rnd_y got %h want %h (result %0d)", y, exp_q[0], got); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            hold = out_valid && !out_ready;
            hold_y = y;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(op, a, shamt));
                issued++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (got != 1024) begin errors++; $display("FAIL rnd_timeout got %0d results want 1024", got); end
        checks++; if (op_count !== 16'd1024) begin errors++; $display("FAIL rnd_op_count got %0d want 1024", op_count); end
    endtask

    task automatic test_wrap();
        int cyc = 0;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd0;
        while ((op_count != 16'hFFFF) && (cyc < 70000)) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_setup got out_valid %b want 1", out_valid); end
        @(negedge clk);
        checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_op_count got %h want 0000", op_count); end
    endtask

    initial begin
        test_reset();
        test_directed("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        test_directed("sra4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        test_directed("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
`ifdef SHIFT_ROTATE_EN
        test_directed("ror1",  2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000);
`else
        test_directed("ror1",  2'b11, 32'h0000_0001, 5'd1,  32'h0000_0000);
`endif
        test_directed("sll0",  2'b00, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234);
        test_directed("sra0",  2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321);
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
